uart_stream_arbiter: RTL
========================

Name: uart_stream_arbiter

Overview:
Shares one byte-level UART transmitter between two sources: the audio sample path and a debug byte stream. Each transfer is sent as a framed packet, a header byte followed by payload. The block sits between the audio/debug producers and the uart_tx byte engine. It sequences bytes through that engine using its tx_dv/tx_done handshake and arbitrates round-robin at packet boundaries.

Parameters:
AUDIO_HDR, 8'hA5, header byte that precedes each audio packet
DBG_HDR, 8'h5A, header byte that precedes each debug packet
MONO, 0, 1 = audio payload is left channel only (2 bytes); 0 = left then right (4 bytes)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
audio_ready  in  1  one-cycle strobe; audio_left/audio_right are valid
audio_left  in  16  left sample
audio_right  in  16  right sample
dbg_valid  in  1  debug byte available
dbg_data  in  8  debug byte
dbg_ready  out  1  debug byte accepted when dbg_valid & dbg_ready
tx_dv  out  1  one-cycle pulse; UART engine loads tx_byte
tx_byte  out  8  byte to transmit
tx_done  in  1  one-cycle pulse from UART engine at end of stop bit
busy  out  1  packet in progress (state != IDLE)
drop_cnt  out  8  audio samples overwritten before being sent; saturates at 255

Behaviour:
- Reset (async, resetn=0): state=IDLE. tx_dv=0, tx_byte=0, dbg_ready=0, busy=0, drop_cnt=0. Pending-audio flag cleared; round-robin pointer = audio-preferred. A packet in flight is abandoned. The UART engine shares the same reset.
- Audio capture: on audio_ready, {audio_right, audio_left} is latched into the pending register and aud_pend is set on the next cycle.
  - If aud_pend was already set and not consumed in that same cycle, the old sample is overwritten and drop_cnt increments, saturating at 255.
  - If audio_ready coincides with the cycle that consumes the pending sample (packet start), the new sample becomes pending and drop_cnt is unchanged.
- Arbitration happens only in IDLE.
  - Requests: audio = aud_pend; debug = dbg_valid.
  - If only one source requests, that source is granted.
  - If both request, grant goes to the source not granted last; the pointer updates on every grant.
  - dbg_ready is combinational: high only in IDLE when debug wins this cycle. dbg_data is captured on that cycle.
  - An audio grant copies the pending register into a 32-bit shift register and clears aud_pend.
- FSM states:
  - IDLE: on grant, load the header byte and byte count, then go to ISSUE. Byte count is audio 5 bytes (3 if MONO), debug 2 bytes.
  - ISSUE: assert tx_dv for exactly one cycle with tx_byte stable, then go to WAIT.
  - WAIT: hold tx_byte. On tx_done, decrement the remaining count. If bytes remain, load the next byte and go to ISSUE; otherwise go to IDLE.
- Byte order:
  - Audio packet: header, L[7:0], L[15:8], R[7:0], R[15:8].
  - Debug packet: header, dbg_data.
- Latency and throughput:
  - First tx_dv comes 2 cycles after audio_ready with IDLE and no contention: latch cycle, then grant cycle, then tx_dv.
  - Next tx_dv comes exactly 2 cycles after each tx_done within a packet, since tx_byte is loaded in WAIT.
  - Back-to-back packets: IDLE costs 1 cycle after the last tx_done.
- tx_done outside WAIT is ignored.
- tx_dv is never asserted twice without an intervening tx_done.
- dbg_valid dropping while not granted is legal; no byte is consumed.

Test Plan:
- Single audio sample, L=16'h1234, R=16'hABCD, MONO=0, UART stub returns tx_done 10 cycles after each tx_dv -> bytes A5,34,12,CD,AB, five tx_dv pulses, busy falls 1 cycle after the 5th tx_done, drop_cnt=0.
- MONO=1, same sample -> bytes A5,34,12 only.
- Debug byte 8'h42 with dbg_valid held -> dbg_ready high for one cycle in IDLE, then bytes 5A,42; a second byte waits until IDLE.
- Audio pending and dbg_valid high simultaneously for three packet slots -> grants alternate audio, debug, audio (pointer reset is audio-preferred).
- Three audio_ready strobes while a debug packet is in WAIT -> only the last sample is sent, drop_cnt=2; 300 overruns -> drop_cnt saturates at 255.
- Assert resetn=0 mid-packet during WAIT -> tx_dv=0, busy=0, drop_cnt=0 immediately; after release, a fresh audio sample is sent from its header.

Source files
------------

// File: rtl/uart_stream_arbiter_if.sv
// Source-side and UART-engine-side signals of the stream arbiter.
// The master modport is the arbiter's view. The slave modport is the
// view of the producers and the byte engine.
interface uart_stream_arbiter_if;
    logic        audio_ready;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        dbg_valid;
    logic [7:0]  dbg_data;
    logic        dbg_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        busy;
    logic [7:0]  drop_cnt;

    modport master (
        input  audio_ready, audio_left, audio_right, dbg_valid, dbg_data, tx_done,
        output dbg_ready, tx_dv, tx_byte, busy, drop_cnt
    );

    modport slave (
        output audio_ready, audio_left, audio_right, dbg_valid, dbg_data, tx_done,
        input  dbg_ready, tx_dv, tx_byte, busy, drop_cnt
    );
endinterface

// File: rtl/uart_stream_arbiter.sv
// Shares one UART byte engine between an audio sample path and a debug
// byte stream. Each transfer goes out as a header byte followed by its
// payload. Round-robin arbitration happens only between packets.
//
// state | meaning
// IDLE  | no packet in flight; arbitrate and load the header on a grant
// ISSUE | tx_dv high for one cycle with tx_byte stable
// WAIT  | byte on the wire; wait for tx_done, then load the next byte
module uart_stream_arbiter #(
    parameter logic [7:0] AUDIO_HDR = 8'hA5,
    parameter logic [7:0] DBG_HDR   = 8'h5A,
    parameter bit         MONO      = 1'b0
) (
    input  logic                   clk,
    input  logic                   resetn,
    uart_stream_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic        aud_pend_q, aud_pend_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        pref_dbg_q, pref_dbg_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_dv_q, tx_dv_d;
    logic        busy_q, busy_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        load_q, load_d;
    logic        grant_aud, grant_dbg;

    // Round-robin grant. It is only valid in IDLE. pref_dbg_q records
    // that audio was granted last.
    always_comb begin
        grant_aud = (state_q == IDLE) && aud_pend_q && (!bus.dbg_valid || !pref_dbg_q);
        grant_dbg = (state_q == IDLE) && bus.dbg_valid && (!aud_pend_q || pref_dbg_q);
    end

    assign bus.dbg_ready = grant_dbg;
    assign bus.tx_dv     = tx_dv_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.busy      = busy_q;
    assign bus.drop_cnt  = drop_cnt_q;

    // Next-state logic: audio capture, packet sequencing and registered outputs.
    // tx_done only sets load_q. The next byte is loaded one cycle later, so
    // each tx_dv comes two cycles after the tx_done that precedes it.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        aud_pend_d = aud_pend_q;
        drop_cnt_d = drop_cnt_q;
        pref_dbg_d = pref_dbg_q;
        shift_d    = shift_q;
        tx_byte_d  = tx_byte_q;
        cnt_d      = cnt_q;
        load_d     = load_q;
        tx_dv_d    = 1'b0;

        if (bus.audio_ready) begin
            pend_d     = {bus.audio_right, bus.audio_left};
            aud_pend_d = 1'b1;
            if (aud_pend_q && !grant_aud && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (grant_aud) begin
            aud_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (grant_aud) begin
                    shift_d    = pend_q;
                    tx_byte_d  = AUDIO_HDR;
                    cnt_d      = MONO ? 3'd3 : 3'd5;
                    pref_dbg_d = 1'b1;
                    tx_dv_d    = 1'b1;
                    state_d    = ISSUE;
                end else if (grant_dbg) begin
                    shift_d    = {24'h0, bus.dbg_data};
                    tx_byte_d  = DBG_HDR;
                    cnt_d      = 3'd2;
                    pref_dbg_d = 1'b0;
                    tx_dv_d    = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (load_q) begin
                    tx_byte_d = shift_q[7:0];
                    shift_d   = {8'h0, shift_q[31:8]};
                    load_d    = 1'b0;
                    tx_dv_d   = 1'b1;
                    state_d   = ISSUE;
                end else if (bus.tx_done) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = IDLE;
                    end else begin
                        load_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset abandons any packet in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            pend_q     <= 32'h0;
            aud_pend_q <= 1'b0;
            drop_cnt_q <= 8'h0;
            pref_dbg_q <= 1'b0;
            shift_q    <= 32'h0;
            tx_byte_q  <= 8'h0;
            tx_dv_q    <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= 3'd0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            aud_pend_q <= aud_pend_d;
            drop_cnt_q <= drop_cnt_d;
            pref_dbg_q <= pref_dbg_d;
            shift_q    <= shift_d;
            tx_byte_q  <= tx_byte_d;
            tx_dv_q    <= tx_dv_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            load_q     <= load_d;
        end
    end

endmodule
